kernel_cache_loader: RTL and testbench
======================================

KERNEL_CACHE_LOADER -- requirements
Module: kernel_cache_loader

Interface
REQ-001 The block SHALL have parameter BUS, default 4, giving the width of the inbound data nibble and of the unit shifted per transfer.
REQ-002 The block SHALL have parameter ROWS, default 3, giving the number of 24-bit cache rows filled per load.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a new cache load.
REQ-006 The block SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-007 The block SHALL have port data_in, input, BUS bits: one nibble of kernel data.
REQ-008 The block SHALL have port data_valid, input, 1 bit: data_in holds a valid nibble.
REQ-009 The block SHALL have port data_ready, output, 1 bit: the block accepts a nibble this cycle.
REQ-010 The block SHALL have port cache, output, unpacked array [0:ROWS-1] of 24 bits: the kernel rows consumed by the ALU.
REQ-011 The block SHALL have port cache_valid, output, 1 bit: cache holds a complete, coherent load.
REQ-012 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse marking load completion.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-015 In IDLE, start=1 SHALL move the FSM to LOAD on the next edge, clear cache_valid, and zero the row and nibble counters.
REQ-016 data_ready SHALL be 1 only in LOAD; busy SHALL be 1 in LOAD and DONE.
REQ-017 A transfer SHALL occur on an edge where data_valid=1 and data_ready=1; no other edge changes cache.
REQ-018 On a transfer, cache[row] SHALL become {cache[row][19:0], data_in}, so the most-significant nibble of each row arrives first.
REQ-019 The nibble counter SHALL count 0..5 per row; on a transfer at count 5 it SHALL wrap to 0 and the row counter SHALL increment.
REQ-020 Rows SHALL fill in order 0, 1, 2; a full load SHALL take exactly 6*ROWS = 18 transfers.
REQ-021 On the 18th transfer the FSM SHALL enter DONE; in DONE, done=1 and data_ready=0 for exactly one cycle, after which the FSM SHALL return to IDLE with cache_valid=1.
REQ-022 cache_valid SHALL rise on the same edge that leaves DONE and SHALL stay 1 until the next accepted start, abort or reset.
REQ-023 data_valid=0 in LOAD SHALL stall the load with no state change; stall length SHALL be unbounded.
REQ-024 start SHALL be ignored in LOAD and DONE.
REQ-025 abort=1 in LOAD SHALL return the FSM to IDLE on the next edge, with cache_valid=0, done never asserted, and partially written cache contents left as they are.
REQ-026 abort SHALL take priority over a simultaneous transfer; the nibble SHALL be discarded.
REQ-027 abort SHALL be ignored in IDLE and DONE.
REQ-028 Rows not yet overwritten during a load SHALL keep their previous value; consumers SHALL qualify cache with cache_valid.

Reset
REQ-029 While rst=1, state SHALL be IDLE, cache SHALL be all zero, counters SHALL be zero, and cache_valid, busy, done and data_ready SHALL be 0, independent of clk.
REQ-030 Reset asserted mid-LOAD SHALL discard the load immediately; after release the block SHALL wait in IDLE for start.

Verification
REQ-031 Reset, then start, then 18 back-to-back nibbles 0x1..0x6 (row 0), 0x7..0xC (row 1), 0xD,0xE,0xF,0x0,0x1,0x2 (row 2) -> cache[0]=24'h123456, cache[1]=24'h789ABC, cache[2]=24'hDEF012; done is high for exactly one cycle, 1 cycle after the 18th transfer; cache_valid=1 thereafter.
REQ-032 Same load with data_valid deasserted 3 cycles after every 2nd nibble -> identical cache values; done arrives 1 cycle after the 18th accepted nibble; no extra shifts occur.
REQ-033 Complete a load of all 24'hAAAAAA, then start and send 7 nibbles of 0x5, then abort -> cache_valid=0, done never pulses, cache[0]=24'h555555, cache[1]=24'hAAAAA5, cache[2]=24'hAAAAAA, state IDLE.
REQ-034 Assert start during LOAD after 4 transfers -> the counters are not reset; the load still completes after 14 further transfers.
REQ-035 Assert rst asynchronously (between clock edges) after 10 transfers -> all outputs go to 0 before the next clk edge; a subsequent start plus 18 nibbles loads correctly.
REQ-036 Present abort together with data_valid=1 on the edge of the 18th nibble -> no transfer, done=0, cache_valid=0, cache[2][3:0] unchanged.

Source files
------------

// File: rtl/kernel_cache_loader.sv
// Kernel cache loader: shifts BUS-wide nibbles MSB-first into ROWS 24-bit rows,
// then pulses done and publishes cache_valid until the next start/abort/reset.
module kernel_cache_loader #(
    parameter int unsigned BUS  = 4,
    parameter int unsigned ROWS = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [BUS-1:0]  data_in,
    input  logic            data_valid,
    output logic            data_ready,
    output logic [23:0]     cache [0:ROWS-1],
    output logic            cache_valid,
    output logic            busy,
    output logic            done
);

    localparam int unsigned ROW_BITS = 24;
    localparam int unsigned NIBS     = ROW_BITS / BUS;
    localparam int unsigned NIB_W    = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [NIB_W-1:0]  nib_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic              start_acc;
    logic              xfer;
    logic              last_xfer;

    // abort wins over a coincident transfer, so it masks xfer
    assign start_acc = (state == IDLE) && start;
    assign xfer      = (state == LOAD) && data_valid && !abort;
    assign last_xfer = xfer && (nib_cnt == NIB_W'(NIBS - 1)) && (row_cnt == ROW_W'(ROWS - 1));

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                if (abort)          state_nx = IDLE;
                else if (last_xfer) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            data_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cache_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            data_ready <= (state_nx == LOAD);
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
            if (start_acc || ((state == LOAD) && abort))
                cache_valid <= 1'b0;
            else if (state == DONE)
                cache_valid <= 1'b1;
        end
    end

    // nibble/row position within the load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_cnt <= '0;
            row_cnt <= '0;
        end else if (start_acc) begin
            nib_cnt <= '0;
            row_cnt <= '0;
        end else if (xfer) begin
            if (nib_cnt == NIB_W'(NIBS - 1)) begin
                nib_cnt <= '0;
                row_cnt <= row_cnt + ROW_W'(1);
            end else begin
                nib_cnt <= nib_cnt + NIB_W'(1);
            end
        end
    end

    // only the addressed row shifts; others hold their previous contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < ROWS; r++)
                cache[r] <= '0;
        end else if (xfer) begin
            for (int unsigned r = 0; r < ROWS; r++)
                if (row_cnt == ROW_W'(r))
                    cache[r] <= {cache[r][ROW_BITS-BUS-1:0], data_in};
        end
    end

endmodule

// File: tb/tb_kernel_cache_loader.sv
// Directed testbench for kernel_cache_loader with hand-computed expectations.
module tb_kernel_cache_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic [23:0] cache [0:2];
    logic        cache_valid;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [23:0] exp_c [3];

    kernel_cache_loader #(.BUS(4), .ROWS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .cache       (cache),
        .cache_valid (cache_valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [3:0] basic_nib(input int i);
        return 4'((i + 1) % 16);
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] v);
        data_in    = v;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({data_ready, cache_valid, busy, done} !== 4'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0000", {data_ready, cache_valid, busy, done}); end
        for (int r = 0; r < 3; r++) begin
            checks++; if (cache[r] !== 24'h0) begin
                failures++; $display("FAIL reset_cache%0d got=%h exp=000000", r, cache[r]); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy, data_ready} !== 2'b00) begin
            failures++; $display("FAIL reset_idle got=%b exp=00", {busy, data_ready}); end
    endtask

    task automatic test_basic_load();
        int d0;
        exp_c = '{24'h123456, 24'h789ABC, 24'hDEF012};
        do_start();
        checks++; if ({busy, data_ready, cache_valid} !== 3'b110) begin
            failures++; $display("FAIL basic_load_entry got=%b exp=110", {busy, data_ready, cache_valid}); end
        d0 = done_cnt;
        for (int i = 0; i < 18; i++) send(basic_nib(i));
        checks++; if ({done, data_ready, busy, cache_valid} !== 4'b1010) begin
            failures++; $display("FAIL basic_done_state got=%b exp=1010", {done, data_ready, busy, cache_valid}); end
        @(posedge clk); #1;
        checks++; if ({done, busy, cache_valid} !== 3'b001) begin
            failures++; $display("FAIL basic_after_done got=%b exp=001", {done, busy, cache_valid}); end
        checks++; if (done_cnt - d0 !== 1) begin
            failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
        for (int r = 0; r < 3; r++) begin
            checks++; if (cache[r] !== exp_c[r]) begin
                failures++; $display("FAIL basic_cache%0d got=%h exp=%h", r, cache[r], exp_c[r]); end
        end
        @(posedge clk); #1;
        checks++; if (cache_valid !== 1'b1) begin
            failures++; $display("FAIL basic_valid_holds got=%b exp=1", cache_valid); end
    endtask

    task automatic test_stall();
        int d0;
        exp_c = '{24'h123456, 24'h789ABC, 24'hDEF012};
        do_start();
        d0 = done_cnt;
        for (int i = 0; i < 18; i++) begin
            send(basic_nib(i));
            if ((i % 2 == 1) && (i != 17)) begin
                repeat (3) @(posedge clk);
                #1;
                checks++; if ({data_ready, busy, done} !== 3'b110) begin
                    failures++; $display("FAIL stall_hold_%0d got=%b exp=110", i, {data_ready, busy, done}); end
            end
        end
        checks++; if (done !== 1'b1) begin
            failures++; $display("FAIL stall_done got=%b exp=1", done); end
        @(posedge clk); #1;
        checks++; if ((done_cnt - d0 !== 1) || (cache_valid !== 1'b1)) begin
            failures++; $display("FAIL stall_complete got=pulses %0d valid %b exp=pulses 1 valid 1", done_cnt - d0, cache_valid); end
        for (int r = 0; r < 3; r++) begin
            checks++; if (cache[r] !== exp_c[r]) begin
                failures++; $display("FAIL stall_cache%0d got=%h exp=%h", r, cache[r], exp_c[r]); end
        end
    endtask

    task automatic test_abort_partial();
        int d0;
        do_start();
        for (int i = 0; i < 18; i++) send(4'hA);
        @(posedge clk); #1;
        checks++; if ((cache_valid !== 1'b1) || (cache[1] !== 24'hAAAAAA)) begin
            failures++; $display("FAIL abort_preload got=valid %b row1 %h exp=valid 1 row1 aaaaaa", cache_valid, cache[1]); end
        exp_c = '{24'h555555, 24'hAAAAA5, 24'hAAAAAA};
        do_start();
        d0 = done_cnt;
        for (int i = 0; i < 7; i++) send(4'h5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if ({cache_valid, busy, done, data_ready} !== 4'b0000) begin
            failures++; $display("FAIL abort_outputs got=%b exp=0000", {cache_valid, busy, done, data_ready}); end
        for (int r = 0; r < 3; r++) begin
            checks++; if (cache[r] !== exp_c[r]) begin
                failures++; $display("FAIL abort_cache%0d got=%h exp=%h", r, cache[r], exp_c[r]); end
        end
        @(posedge clk); #1;
        checks++; if ((done_cnt != d0) || (busy !== 1'b0)) begin
            failures++; $display("FAIL abort_no_done got=pulses %0d busy %b exp=pulses 0 busy 0", done_cnt - d0, busy); end
    endtask

    task automatic test_start_in_load();
        exp_c = '{24'h123456, 24'h789ABC, 24'hDEF012};
        do_start();
        for (int i = 0; i < 4; i++) send(basic_nib(i));
        start = 1'b1;
        send(basic_nib(4));
        start = 1'b0;
        checks++; if ({busy, data_ready} !== 2'b11) begin
            failures++; $display("FAIL start_ignored got=%b exp=11", {busy, data_ready}); end
        for (int i = 5; i < 17; i++) send(basic_nib(i));
        checks++; if ({done, data_ready} !== 2'b01) begin
            failures++; $display("FAIL start_not_early got=%b exp=01", {done, data_ready}); end
        send(basic_nib(17));
        checks++; if (done !== 1'b1) begin
            failures++; $display("FAIL start_done got=%b exp=1", done); end
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) begin
            checks++; if (cache[r] !== exp_c[r]) begin
                failures++; $display("FAIL start_cache%0d got=%h exp=%h", r, cache[r], exp_c[r]); end
        end
    endtask

    task automatic test_async_reset();
        exp_c = '{24'h123456, 24'h789ABC, 24'hDEF012};
        do_start();
        for (int i = 0; i < 10; i++) send(4'h3);
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({data_ready, cache_valid, busy, done} !== 4'b0) begin
            failures++; $display("FAIL async_rst_outputs got=%b exp=0000", {data_ready, cache_valid, busy, done}); end
        for (int r = 0; r < 3; r++) begin
            checks++; if (cache[r] !== 24'h0) begin
                failures++; $display("FAIL async_rst_cache%0d got=%h exp=000000", r, cache[r]); end
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL async_rst_idle got=%b exp=0", busy); end
        do_start();
        for (int i = 0; i < 18; i++) send(basic_nib(i));
        @(posedge clk); #1;
        checks++; if (cache_valid !== 1'b1) begin
            failures++; $display("FAIL async_reload_valid got=%b exp=1", cache_valid); end
        for (int r = 0; r < 3; r++) begin
            checks++; if (cache[r] !== exp_c[r]) begin
                failures++; $display("FAIL async_reload_cache%0d got=%h exp=%h", r, cache[r], exp_c[r]); end
        end
    endtask

    task automatic test_abort_last();
        int d0;
        do_start();
        d0 = done_cnt;
        for (int i = 0; i < 17; i++) send(4'h9);
        data_in    = 4'h7;
        data_valid = 1'b1;
        abort      = 1'b1;
        @(posedge clk); #1;
        abort      = 1'b0;
        data_valid = 1'b0;
        checks++; if ({done, cache_valid, busy} !== 3'b000) begin
            failures++; $display("FAIL abort_last_outputs got=%b exp=000", {done, cache_valid, busy}); end
        checks++; if (cache[2] !== 24'h299999) begin
            failures++; $display("FAIL abort_last_row2 got=%h exp=299999", cache[2]); end
        checks++; if (cache[0] !== 24'h999999) begin
            failures++; $display("FAIL abort_last_row0 got=%h exp=999999", cache[0]); end
        @(posedge clk); #1;
        checks++; if (done_cnt != d0) begin
            failures++; $display("FAIL abort_last_no_done got=%0d exp=0", done_cnt - d0); end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        data_in    = 4'h0;
        data_valid = 1'b0;
        test_reset();
        test_basic_load();
        test_stall();
        test_abort_partial();
        test_start_in_load();
        test_async_reset();
        test_abort_last();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
